// File: rtl/avmm_paged_window_if.sv
// Avalon-MM signal bundle for avmm_paged_window.
// It carries the CSR slave (BAR0) and the data-window slave (BAR2).
// The host bridge drives it through the master modport; the window implements the slave modport.
interface avmm_paged_window_if #(
  parameter int DW = 64,
  parameter int AW = 4
);
  logic [3:0]      csr_address;
  logic            csr_write;
  logic [31:0]     csr_writedata;
  logic            csr_read;
  logic [31:0]     csr_readdata;
  logic            csr_readdatavalid;
  logic [AW-1:0]   win_address;
  logic            win_write;
  logic [DW-1:0]   win_writedata;
  logic [DW/8-1:0] win_byteenable;
  logic            win_read;
  logic            win_waitrequest;
  logic [DW-1:0]   win_readdata;
  logic            win_readdatavalid;

  modport master (
    output csr_address, csr_write, csr_writedata, csr_read,
    input  csr_readdata, csr_readdatavalid,
    output win_address, win_write, win_writedata, win_byteenable, win_read,
    input  win_waitrequest, win_readdata, win_readdatavalid
  );

  modport slave (
    input  csr_address, csr_write, csr_writedata, csr_read,
    output csr_readdata, csr_readdatavalid,
    input  win_address, win_write, win_writedata, win_byteenable, win_read,
    output win_waitrequest, win_readdata, win_readdatavalid
  );
endinterface

// File: rtl/avmm_paged_window.sv
// Paged memory window behind the PCIe Avalon-MM bridge.
// The CSR slave selects a page. The window slave accesses DW-bit words of that page
// in an internal RAM of PAGE_COUNT*PAGE_BYTES bytes.
// Optional write checksum: define AVMM_WIN_CHECKSUM_EN to build the SUM accumulator at CSR 0x20.
module avmm_paged_window #(
  parameter int          DW         = 64,
  parameter int          PAGE_BYTES = 128,
  parameter int          PAGE_COUNT = 4,
  parameter logic [31:0] ID_VALUE   = 32'h5057_0001
) (
  input logic                clk_in,
  input logic                rst,
  avmm_paged_window_if.slave bus
);

  localparam int WORDS = PAGE_BYTES * 8 / DW;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DEPTH = PAGE_COUNT * WORDS;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE    = DW / 8;

  localparam logic [15:0]   LAST_PAGE    = 16'(PAGE_COUNT - 1);
  localparam logic [16:0]   PAGE_LIMIT   = 17'(PAGE_COUNT);
  localparam logic [AW-1:0] LAST_WORD    = AW'(WORDS - 1);
  localparam logic [31:0]   PARAMS_VALUE = {16'(PAGE_COUNT - 1), 8'($clog2(PAGE_BYTES)), 8'(DW / 8)};

  typedef enum logic {
    RUN,
    SWITCH
  } state_t;

  state_t state_q, state_d;
  logic   waitReq;

  logic [15:0]   page_q, page_d;
  logic          autoInc_q, autoInc_d;
  logic          wrap_q, wrap_d;
  logic          oor_q, oor_d;
  logic [31:0]   accCnt_q, accCnt_d;
  logic [31:0]   csrData_q, csrData_d;
  logic          csrValid_q;
  logic          rdValid1_q;
  logic          rdOor1_q;
  logic [IW-1:0] rdIdx_q;
  logic [DW-1:0] winData_q;
  logic          winValid_q;

  logic [DW-1:0] mem [DEPTH];

  logic          accept;
  logic          acceptWrite;
  logic          acceptRead;
  logic          inRange;
  logic          csrPageWr;
  logic          csrCtrlWr;
  logic          csrStatusWr;
  logic          incHit;
  logic          pageLoad;
  logic          oorEvent;
  logic [IW-1:0] winIdx;
  logic [31:0]   sumValue;
  logic          unusedHighBits;

  // Command handshake: the page is sampled from page_q at acceptance; write wins over a simultaneous read.
  always_comb begin
    accept      = (bus.win_read | bus.win_write) & ~waitReq;
    acceptWrite = accept & bus.win_write;
    acceptRead  = accept & bus.win_read & ~bus.win_write;
    inRange     = ({1'b0, page_q} < PAGE_LIMIT);
    winIdx      = IW'(32'(page_q) * 32'(WORDS) + 32'(bus.win_address));
    csrPageWr   = bus.csr_write & (bus.csr_address == 4'h4);
    csrCtrlWr   = bus.csr_write & (bus.csr_address == 4'h5);
    csrStatusWr = bus.csr_write & (bus.csr_address == 4'h6);
    incHit      = accept & autoInc_q & (bus.win_address == LAST_WORD);
  end

  // Page select, control bits, sticky out-of-range flag and command counter; CSR page writes beat auto-increment.
  always_comb begin
    page_d    = page_q;
    autoInc_d = autoInc_q;
    wrap_d    = wrap_q;
    oor_d     = oor_q;
    accCnt_d  = accCnt_q;
    pageLoad  = 1'b0;
    oorEvent  = 1'b0;
    if (csrPageWr) begin
      page_d   = bus.csr_writedata[15:0];
      pageLoad = 1'b1;
    end else if (incHit) begin
      page_d   = (page_q == LAST_PAGE && wrap_q) ? 16'h0000 : page_q + 16'h0001;
      pageLoad = 1'b1;
    end
    if (csrCtrlWr) begin
      autoInc_d = bus.csr_writedata[0];
      wrap_d    = bus.csr_writedata[1];
    end
    if (accept) begin
      accCnt_d = accCnt_q + 32'd1;
    end
    oorEvent = (accept & ~inRange) | (pageLoad & ({1'b0, page_d} >= PAGE_LIMIT));
    if (oorEvent) begin
      oor_d = 1'b1;
    end else if (csrStatusWr & bus.csr_writedata[0]) begin
      oor_d = 1'b0;
    end
  end

  // FSM next state: any page change stalls the window for one clock in SWITCH.
  always_comb begin
    state_d = state_q;
    waitReq = 1'b0;
    case (state_q)
      RUN:     state_d = pageLoad ? SWITCH : RUN;
      SWITCH: begin
        waitReq = 1'b1;
        state_d = pageLoad ? SWITCH : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // CSR read mux; unmapped offsets return zero.
  always_comb begin
    csrData_d = csrData_q;
    if (bus.csr_read) begin
      case (bus.csr_address)
        4'h0:    csrData_d = ID_VALUE;
        4'h1:    csrData_d = PARAMS_VALUE;
        4'h4:    csrData_d = {16'h0000, page_q};
        4'h5:    csrData_d = {30'd0, wrap_q, autoInc_q};
        4'h6:    csrData_d = {30'd0, inRange, oor_q};
        4'h7:    csrData_d = accCnt_q;
        4'h8:    csrData_d = sumValue;
        default: csrData_d = 32'd0;
      endcase
    end
  end

  // Control state and the two-stage read pipeline; reset squashes any read still in flight.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= RUN;
      page_q     <= '0;
      autoInc_q  <= 1'b0;
      wrap_q     <= 1'b0;
      oor_q      <= 1'b0;
      accCnt_q   <= '0;
      csrData_q  <= '0;
      csrValid_q <= 1'b0;
      rdValid1_q <= 1'b0;
      rdOor1_q   <= 1'b0;
      rdIdx_q    <= '0;
      winData_q  <= '0;
      winValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      autoInc_q  <= autoInc_d;
      wrap_q     <= wrap_d;
      oor_q      <= oor_d;
      accCnt_q   <= accCnt_d;
      csrData_q  <= csrData_d;
      csrValid_q <= bus.csr_read;
      rdValid1_q <= acceptRead;
      rdOor1_q   <= ~inRange;
      rdIdx_q    <= inRange ? winIdx : '0;
      winValid_q <= rdValid1_q;
      if (rdValid1_q) begin
        winData_q <= rdOor1_q ? '0 : mem[rdIdx_q];
      end
    end
  end

  // RAM byte-lane writes; out-of-range writes and writes in a reset cycle are discarded.
  always_ff @(posedge clk_in) begin
    if (!rst && acceptWrite && inRange) begin
      for (int b = 0; b < BE; b++) begin
        if (bus.win_byteenable[b]) begin
          mem[winIdx][b*8 +: 8] <= bus.win_writedata[b*8 +: 8];
        end
      end
    end
  end

`ifdef AVMM_WIN_CHECKSUM_EN
  localparam int LANES = DW / 32;

  logic [31:0] sum_q, sum_d;
  logic [31:0] addend;
  logic [31:0] laneVal;
  logic        clrSum;

  // Checksum addend: 32-bit lane sum of the write data with disabled bytes forced to zero.
  always_comb begin
    addend  = '0;
    laneVal = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < 4; b++) begin
        laneVal[b*8 +: 8] = bus.win_byteenable[l*4 + b] ? bus.win_writedata[l*32 + b*8 +: 8] : 8'h00;
      end
      addend = addend + laneVal;
    end
    clrSum = csrCtrlWr & bus.csr_writedata[2];
    sum_d  = (clrSum ? 32'd0 : sum_q) + ((acceptWrite & inRange) ? addend : 32'd0);
  end

  // Checksum accumulator; a clear and an accepted write in the same cycle leave just that write's addend.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sumValue = sum_q;
`else
  logic unusedClrBit;

  assign sumValue     = 32'd0;
  assign unusedClrBit = bus.csr_writedata[2];
`endif

  assign unusedHighBits = ^bus.csr_writedata[31:16];

  assign bus.csr_readdata      = csrData_q;
  assign bus.csr_readdatavalid = csrValid_q;
  assign bus.win_waitrequest   = waitReq;
  assign bus.win_readdata      = winData_q;
  assign bus.win_readdatavalid = winValid_q;

endmodule

// File: tb/tb_avmm_paged_window.sv
// Directed bench for avmm_paged_window (DW=64, 128-byte pages, 4 pages).
// Expected values are hand-computed constants or the fixed data pattern from dataFor().
module tb_avmm_paged_window;

  logic clk_in = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   accExp      = 0;

  avmm_paged_window_if #(.DW(64), .AW(4)) bus();

  avmm_paged_window #(
    .DW(64),
    .PAGE_BYTES(128),
    .PAGE_COUNT(4),
    .ID_VALUE(32'h5057_0001)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .bus(bus)
  );

  // 100 MHz clock
  always #5 clk_in = ~clk_in;

  // Global time bound so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every vector and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] dataFor(input int p, input int i);
    return 64'h0123_4567_89AB_CD00 + 64'(p * 16 + i);
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (bus.win_waitrequest === 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (n >= 8) checkOutput({tag, "_wait_timeout"}, 64'(bus.win_waitrequest), 64'd0);
  endtask

  task automatic csrWrite(input logic [3:0] addr, input logic [31:0] data);
    bus.csr_address   = addr;
    bus.csr_writedata = data;
    bus.csr_write     = 1'b1;
    tick();
    bus.csr_write     = 1'b0;
  endtask

  task automatic csrCheck(input string tag, input logic [3:0] addr, input logic [31:0] expected);
    bus.csr_address = addr;
    bus.csr_read    = 1'b1;
    tick();
    bus.csr_read    = 1'b0;
    checkOutput({tag, "_valid"}, 64'(bus.csr_readdatavalid), 64'd1);
    checkOutput(tag, 64'(bus.csr_readdata), 64'(expected));
  endtask

  task automatic winWrite(input logic [3:0] addr, input logic [63:0] data, input logic [7:0] be);
    waitReady("wr");
    bus.win_address    = addr;
    bus.win_writedata  = data;
    bus.win_byteenable = be;
    bus.win_write      = 1'b1;
    tick();
    bus.win_write      = 1'b0;
    accExp++;
  endtask

  // Called right after the acceptance edge; expects valid on the second edge after acceptance
  task automatic collectRead(input string tag, input logic [63:0] expected);
    int lat = 1;
    while (bus.win_readdatavalid !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_lat"}, 64'(lat), 64'd2);
    checkOutput(tag, bus.win_readdata, expected);
  endtask

  task automatic winCheck(input string tag, input logic [3:0] addr, input logic [63:0] expected);
    waitReady(tag);
    bus.win_address = addr;
    bus.win_read    = 1'b1;
    tick();
    bus.win_read    = 1'b0;
    accExp++;
    collectRead(tag, expected);
  endtask

  // Cycle in which a window read and a CSR PAGE write land together
  task automatic applyStimulus(input logic [3:0] winAddr, input logic [31:0] newPage);
    waitReady("combo");
    bus.win_address   = winAddr;
    bus.win_read      = 1'b1;
    bus.csr_address   = 4'h4;
    bus.csr_writedata = newPage;
    bus.csr_write     = 1'b1;
    tick();
    bus.win_read      = 1'b0;
    bus.csr_write     = 1'b0;
    accExp++;
  endtask

  logic [63:0] got[$];
  int          seenAt[$];

  initial begin
    rst                = 1'b1;
    bus.csr_address    = '0;
    bus.csr_write      = 1'b0;
    bus.csr_writedata  = '0;
    bus.csr_read       = 1'b0;
    bus.win_address    = '0;
    bus.win_write      = 1'b0;
    bus.win_writedata  = '0;
    bus.win_byteenable = '0;
    bus.win_read       = 1'b0;
    repeat (3) tick();

    // Reset values
    checkOutput("rst_csr_rdata", 64'(bus.csr_readdata), 64'd0);
    checkOutput("rst_csr_valid", 64'(bus.csr_readdatavalid), 64'd0);
    checkOutput("rst_win_rdata", bus.win_readdata, 64'd0);
    checkOutput("rst_win_valid", 64'(bus.win_readdatavalid), 64'd0);
    checkOutput("rst_waitreq", 64'(bus.win_waitrequest), 64'd0);
    rst = 1'b0;
    tick();
    csrCheck("id", 4'h0, 32'h5057_0001);
    csrCheck("params", 4'h1, 32'h0003_0708);
    csrCheck("rst_page", 4'h4, 32'd0);
    csrCheck("rst_ctrl", 4'h5, 32'd0);
    csrCheck("rst_status", 4'h6, 32'h2);
    csrCheck("rst_acccnt", 4'h7, 32'd0);
    csrCheck("unmapped", 4'hC, 32'd0);

    // Fill all four pages; each PAGE write stalls the window for exactly one clock
    for (int p = 0; p < 4; p++) begin
      csrWrite(4'h4, 32'(p));
      checkOutput("switch_wait_hi", 64'(bus.win_waitrequest), 64'd1);
      tick();
      checkOutput("switch_wait_lo", 64'(bus.win_waitrequest), 64'd0);
      for (int i = 0; i < 16; i++) winWrite(4'(i), dataFor(p, i), 8'hFF);
    end
    for (int p = 0; p < 4; p++) begin
      csrWrite(4'h4, 32'(p));
      for (int i = 0; i < 16; i++) winCheck("fill_rd", 4'(i), dataFor(p, i));
    end
    csrCheck("acccnt_fill", 4'h7, 32'(accExp));

    // Back-to-back pipelined reads on page 3
    waitReady("pipe");
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        bus.win_address = 4'(c);
        bus.win_read    = 1'b1;
      end else begin
        bus.win_read = 1'b0;
      end
      tick();
      if (bus.win_readdatavalid === 1'b1) begin
        got.push_back(bus.win_readdata);
        seenAt.push_back(c);
      end
    end
    accExp += 3;
    checkOutput("pipe_count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) begin
        checkOutput("pipe_data", got[k], dataFor(3, k));
        checkOutput("pipe_cycle", 64'(seenAt[k]), 64'(k + 1));
      end
    end

    // Auto-increment past the last page without wrap
    csrWrite(4'h5, 32'h1);
    csrWrite(4'h4, 32'd3);
    winWrite(4'hF, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    csrCheck("oor_page", 4'h4, 32'd4);
    csrCheck("oor_status", 4'h6, 32'h1);
    winWrite(4'h0, 64'h5555_5555_5555_5555, 8'hFF);
    winCheck("oor_rd", 4'h0, 64'd0);
    csrWrite(4'h6, 32'h1);
    csrCheck("oor_w1c", 4'h6, 32'h0);
    csrWrite(4'h5, 32'h0);
    csrWrite(4'h4, 32'd0);
    winCheck("oor_drop_p0", 4'h0, dataFor(0, 0));
    csrWrite(4'h4, 32'd3);
    winCheck("lastword_p3", 4'hF, 64'hDEAD_BEEF_0BAD_F00D);
    winCheck("p3_w14", 4'hE, dataFor(3, 14));
    csrCheck("acccnt_oor", 4'h7, 32'(accExp));

    // Auto-increment with wrap, then a same-cycle PAGE write that beats it
    csrWrite(4'h5, 32'h3);
    csrWrite(4'h4, 32'd3);
    winCheck("wrap_rd", 4'hF, 64'hDEAD_BEEF_0BAD_F00D);
    csrCheck("wrap_page", 4'h4, 32'd0);
    csrCheck("wrap_status", 4'h6, 32'h2);
    csrWrite(4'h4, 32'd3);
    applyStimulus(4'hF, 32'd2);
    collectRead("combo_rd", 64'hDEAD_BEEF_0BAD_F00D);
    csrCheck("combo_page", 4'h4, 32'd2);

    // Byte enables on page 1 word 0
    csrWrite(4'h5, 32'h0);
    csrWrite(4'h4, 32'd1);
    winWrite(4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    winWrite(4'h0, 64'h0, 8'h0F);
    winCheck("be_rd", 4'h0, 64'hFFFF_FFFF_0000_0000);
    csrCheck("acccnt_be", 4'h7, 32'(accExp));

    // Checksum clear and accumulate; CLR_SUM never reads back as set
    csrWrite(4'h5, 32'h4);
    csrCheck("ctrl_selfclr", 4'h5, 32'h0);
`ifdef AVMM_WIN_CHECKSUM_EN
    csrCheck("sum_clr", 4'h8, 32'd0);
    winWrite(4'h2, 64'h0000_0002_0000_0001, 8'hFF);
    csrCheck("sum_3", 4'h8, 32'd3);
    winWrite(4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    csrCheck("sum_be0", 4'h8, 32'd3);
    winWrite(4'h4, 64'h0000_0010_0000_0100, 8'hF0);
    csrCheck("sum_hi", 4'h8, 32'd19);
`else
    winWrite(4'h2, 64'h0000_0002_0000_0001, 8'hFF);
    winWrite(4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    csrCheck("sum_off", 4'h8, 32'd0);
`endif
    winCheck("be0_keep", 4'h3, dataFor(1, 3));

    // Reset in the middle of a read, with a write presented in the reset cycle
    csrWrite(4'h4, 32'd0);
    waitReady("rstmid");
    bus.win_address = 4'h5;
    bus.win_read    = 1'b1;
    tick();
    bus.win_read       = 1'b0;
    rst                = 1'b1;
    bus.win_address    = 4'h1;
    bus.win_writedata  = 64'hBAD0_BAD0_BAD0_BAD0;
    bus.win_byteenable = 8'hFF;
    bus.win_write      = 1'b1;
    tick();
    checkOutput("rstmid_valid", 64'(bus.win_readdatavalid), 64'd0);
    checkOutput("rstmid_wait", 64'(bus.win_waitrequest), 64'd0);
    rst           = 1'b0;
    bus.win_write = 1'b0;
    tick();
    checkOutput("rstmid_valid2", 64'(bus.win_readdatavalid), 64'd0);
    accExp = 0;
    csrCheck("rstmid_acccnt", 4'h7, 32'd0);
    csrCheck("rstmid_page", 4'h4, 32'd0);
    winCheck("rstmid_nowrite", 4'h1, dataFor(0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
